// File: rtl/pcs_sync_rx_lock.sv
// 64b/66b receive block-lock tracker: counts sync headers per window,
// declares block lock and requests gearbox slips on misalignment.
module pcs_sync_rx_lock #(
    parameter int HEAD_W       = 2,
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    output logic              slip_v_o,
    output logic              lock_v_o
);

    localparam logic [6:0] CNT_MAX = 7'(SH_CNT_MAX);
    localparam logic [4:0] INV_MAX = 5'(SH_INVLD_MAX);

    logic [6:0] sh_cnt_q, sh_cnt_d, sh_cnt_n;
    logic [4:0] sh_invld_q, sh_invld_d, sh_invld_n;
    logic       lock_q, lock_d;
    logic       slip_q, slip_d;
    logic       head_ok;

    // Next-state: loss of signal, slip, window end, or plain counting.
    always_comb begin
        sh_cnt_d   = sh_cnt_q;
        sh_invld_d = sh_invld_q;
        lock_d     = lock_q;
        slip_d     = 1'b0;
        head_ok    = head_i[1] ^ head_i[0];
        sh_cnt_n   = sh_cnt_q + 7'd1;
        sh_invld_n = sh_invld_q + {4'd0, ~head_ok};
        if (!valid_i) begin
            lock_d     = 1'b0;
            sh_cnt_d   = '0;
            sh_invld_d = '0;
        end else if (!head_ok && (!lock_q || sh_invld_n == INV_MAX)) begin
            // Bad alignment: slip one bit and restart acquisition.
            slip_d     = 1'b1;
            lock_d     = 1'b0;
            sh_cnt_d   = '0;
            sh_invld_d = '0;
        end else if (sh_cnt_n == CNT_MAX) begin
            // A fully clean window grants lock; otherwise lock is held.
            if (sh_invld_n == 5'd0) begin
                lock_d = 1'b1;
            end
            sh_cnt_d   = '0;
            sh_invld_d = '0;
        end else begin
            sh_cnt_d   = sh_cnt_n;
            sh_invld_d = sh_invld_n;
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            sh_cnt_q   <= '0;
            sh_invld_q <= '0;
            lock_q     <= 1'b0;
            slip_q     <= 1'b0;
        end else begin
            sh_cnt_q   <= sh_cnt_d;
            sh_invld_q <= sh_invld_d;
            lock_q     <= lock_d;
            slip_q     <= slip_d;
        end
    end

    assign slip_v_o = slip_q;
    assign lock_v_o = lock_q;

endmodule

// File: tb/tb_pcs_sync_rx_lock.sv
// Scoreboard bench for pcs_sync_rx_lock: the driver queues the expected
// registered outputs per sampled header, a monitor compares after each edge.
module tb_pcs_sync_rx_lock;

    logic       clk;
    logic       nreset;
    logic       valid_i;
    logic [1:0] head_i;
    logic       slip_v_o;
    logic       lock_v_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic  slip;
        logic  lock;
        string tag;
    } exp_t;

    exp_t exp_q[$];

    pcs_sync_rx_lock #(
        .HEAD_W(2),
        .SH_CNT_MAX(64),
        .SH_INVLD_MAX(16)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .valid_i(valid_i),
        .head_i(head_i),
        .slip_v_o(slip_v_o),
        .lock_v_o(lock_v_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry per sampled edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (slip_v_o !== e.slip || lock_v_o !== e.lock) begin
                    failures++;
                    $display("FAIL %s: slip/lock got %b/%b expected %b/%b",
                             e.tag, slip_v_o, lock_v_o, e.slip, e.lock);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [1:0] h,
                        input logic es, input logic el, input string tag);
        exp_t e;
        @(negedge clk);
        valid_i = v;
        head_i  = h;
        e.slip  = es;
        e.lock  = el;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    function automatic logic [1:0] good_hdr();
        return 2'($urandom_range(1, 2));
    endfunction

    task automatic direct_check(input string tag);
        checks++;
        if (slip_v_o !== 1'b0 || lock_v_o !== 1'b0) begin
            failures++;
            $display("FAIL %s: slip/lock got %b/%b expected 0/0",
                     tag, slip_v_o, lock_v_o);
        end
    endtask

    initial begin
        nreset  = 1'b0;
        valid_i = 1'b0;
        head_i  = 2'b00;

        // Reset with random inputs: outputs clear without a clock edge.
        #2;
        nreset  = 1'b1;
        valid_i = 1'($urandom_range(0, 1));
        head_i  = 2'($urandom_range(0, 3));
        #1;
        direct_check("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            valid_i = 1'($urandom_range(0, 1));
            head_i  = 2'($urandom_range(0, 3));
            #1;
            direct_check($sformatf("reset_hold_%0d", i));
        end
        @(negedge clk);
        valid_i = 1'b0;
        nreset  = 1'b0;

        // 100 clean headers: lock at the 64th, no slips.
        for (int i = 0; i < 100; i++)
            step(1'b1, good_hdr(), 1'b0, i >= 63, $sformatf("acq_%0d", i));

        // Signal loss while locked; re-acquire after exactly 64 headers.
        step(1'b0, 2'b01, 1'b0, 1'b0, "los_0");
        step(1'b0, 2'b10, 1'b0, 1'b0, "los_1");
        for (int i = 0; i < 64; i++)
            step(1'b1, good_hdr(), 1'b0, i >= 63, $sformatf("reacq_%0d", i));

        // Locked window with 15 invalid headers keeps lock.
        for (int i = 0; i < 64; i++) begin
            if (i % 4 == 0 && i < 60)
                step(1'b1, 2'b11, 1'b0, 1'b1, $sformatf("inv15_%0d", i));
            else
                step(1'b1, good_hdr(), 1'b0, 1'b1, $sformatf("inv15_%0d", i));
        end

        // Next window: the 16th invalid header slips and drops lock.
        for (int i = 0; i <= 45; i++) begin
            if (i == 45)
                step(1'b1, 2'b00, 1'b1, 1'b0, "inv16_slip");
            else if (i % 3 == 0)
                step(1'b1, 2'b11, 1'b0, 1'b1, $sformatf("inv16_%0d", i));
            else
                step(1'b1, good_hdr(), 1'b0, 1'b1, $sformatf("inv16_%0d", i));
        end

        // Unlocked: one bad header (00, then 11) slips immediately.
        for (int i = 0; i < 10; i++)
            step(1'b1, good_hdr(), 1'b0, 1'b0, $sformatf("pre00_%0d", i));
        step(1'b1, 2'b00, 1'b1, 1'b0, "slip00");
        for (int i = 0; i < 10; i++)
            step(1'b1, good_hdr(), 1'b0, 1'b0, $sformatf("pre11_%0d", i));
        step(1'b1, 2'b11, 1'b1, 1'b0, "slip11");
        for (int i = 0; i < 64; i++)
            step(1'b1, good_hdr(), 1'b0, i >= 63, $sformatf("postslip_%0d", i));

        // Gap after 63 headers discards progress.
        step(1'b0, 2'b01, 1'b0, 1'b0, "drop");
        for (int i = 0; i < 63; i++)
            step(1'b1, good_hdr(), 1'b0, 1'b0, $sformatf("gap63_%0d", i));
        step(1'b0, 2'b10, 1'b0, 1'b0, "gap");
        for (int i = 0; i < 64; i++)
            step(1'b1, good_hdr(), 1'b0, i >= 63, $sformatf("gap64_%0d", i));

        // Drain the scoreboard, then reset asynchronously while locked.
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending got %0d expected 0", exp_q.size());
        end
        #2;
        nreset = 1'b1;
        #1;
        direct_check("reset_mid_lock");
        valid_i = 1'b1;
        head_i  = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        direct_check("reset_mid_hold");
        @(negedge clk);
        nreset = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
